alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; SHALL be a power of two, 8..64.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width; SHALL NOT be overridden.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 aluop  input  4  operation code, per REQ-012.
REQ-008 a, b  input  WIDTH each  operands.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 f  output  WIDTH result; zero  output  1  f == 0; err  output  1  illegal aluop.

Function
REQ-012 Opcodes: 0 AND, 1 OR, 2 NOT a, 3 ADD, 4 SUB, 5 SHL, 6 SHR logical, 7 SRA, 8 XOR, 9 SLT signed, 10 SLTU, 11 MUL (low WIDTH bits of a*b); 12..15 illegal.
REQ-013 ADD/SUB SHALL wrap modulo 2^WIDTH; no carry/overflow output.
REQ-014 Shifts SHALL use b[SHW-1:0] only; upper bits of b ignored.
REQ-015 SLT/SLTU SHALL return 1 or 0, zero-extended to WIDTH.
REQ-016 Illegal opcode SHALL give f=0, zero=1, err=1; otherwise err=0.
REQ-017 Request accepted on an edge where in_valid && in_ready; a, b, aluop SHALL be registered then.
REQ-018 FSM states: IDLE, EXEC, MUL, HOLD.
REQ-019 IDLE: on accept, go to MUL if aluop==11, else EXEC.
REQ-020 EXEC: compute from registered operands, load f/zero/err, go to HOLD (one cycle).
REQ-021 MUL: iterative shift-add, one bit of b per cycle, exactly WIDTH cycles, then load f/zero/err and go to HOLD.
REQ-022 HOLD: out_valid=1; f, zero, err SHALL be held stable until out_ready.
REQ-023 HOLD with out_ready: new accept if in_valid (go to EXEC/MUL), else IDLE.
REQ-024 in_ready SHALL equal (state==IDLE) || (state==HOLD && out_ready); combinational from state and out_ready only.
REQ-025 out_valid SHALL be 1 only in HOLD.
REQ-026 Latency, accept edge to first cycle out_valid high: 2 for non-MUL, WIDTH+2 for MUL.
REQ-027 Sustained throughput with out_ready held high: one result per 2 cycles (non-MUL).
REQ-028 Inputs while in_ready=0 SHALL be ignored; no request queued.
REQ-029 f/zero/err outside HOLD: retain last loaded value.

Reset
REQ-030 While rst_n=0 at an edge: state IDLE, out_valid 0, f 0, zero 0, err 0, MUL counter 0.
REQ-031 in_ready SHALL be 0 in any cycle rst_n=0.
REQ-032 Reset in EXEC, MUL or HOLD SHALL discard the operation; no result produced afterwards.

Structure
REQ-033 Package alu_mc_pkg SHALL hold the aluop enum (4-bit) and FSM state enum.
REQ-034 Multiplier SHALL be sub-module alu_mc_mul (start, a, b, done, p), WIDTH parameter, own counter.
REQ-035 No combinational path from in_valid, a, b or aluop to any output.

Verification (WIDTH=32)
REQ-036 ADD 0xFFFFFFFF+0x1 -> f=0x0, zero=1, err=0, out_valid 2 cycles after accept.
REQ-037 SRA a=0x80000000 b=36 -> f=0xF8000000; SHR same operands -> 0x08000000.
REQ-038 SLT 0xFFFFFFFF,0x1 -> f=1; SLTU same -> f=0.
REQ-039 MUL 0x00010003*0x5 -> f=0x0005000F, out_valid 34 cycles after accept, in_ready=0 throughout.
REQ-040 Hold out_ready=0 5 cycles in HOLD -> f stable, in_ready=0; then out_ready=1 with in_valid=1 -> new accept that edge; aluop=12 -> f=0, err=1.
REQ-041 rst_n=0 one cycle mid-MUL -> next cycle out_valid=0, f=0, in_ready=1; no late result.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// Shared types for the multi-cycle ALU: operation codes and controller states.
package alu_mc_pkg;

  // 4-bit operation codes; values 12..15 are illegal.
  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_NOT  = 4'd2,
    OP_ADD  = 4'd3,
    OP_SUB  = 4'd4,
    OP_SHL  = 4'd5,
    OP_SHR  = 4'd6,
    OP_SRA  = 4'd7,
    OP_XOR  = 4'd8,
    OP_SLT  = 4'd9,
    OP_SLTU = 4'd10,
    OP_MUL  = 4'd11
  } aluop_e;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  // True when the opcode selects the iterative multiplier.
  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == OP_MUL);
  endfunction

endpackage

// File: rtl/alu_mc_mul.sv
// Iterative shift-add multiplier: consumes one bit of b per cycle for WIDTH
// cycles and keeps only the low WIDTH bits of the product.
module alu_mc_mul
  #(parameter int WIDTH = 32)
  (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] p
  );

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [WIDTH-1:0] acc_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r;

  // Done is decoded from registers only, so it never depends on start/a/b.
  assign done = busy_r && (cnt_r == CNT_ZERO);
  assign p    = acc_r;

  // Load operands on start, then add-and-shift once per cycle until the counter empties.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {WIDTH{1'b0}};
      cnt_r    <= CNT_ZERO;
      busy_r   <= 1'b0;
    end else if (start) begin
      mcand_r  <= a;
      mplier_r <= b;
      acc_r    <= {WIDTH{1'b0}};
      cnt_r    <= CNT_FULL;
      busy_r   <= 1'b1;
    end else if (busy_r && (cnt_r != CNT_ZERO)) begin
      acc_r    <= mplier_r[0] ? (acc_r + mcand_r) : acc_r;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      cnt_r    <= cnt_r - CNT_ONE;
    end else if (done) begin
      busy_r   <= 1'b0;
    end else begin
      busy_r   <= busy_r;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes on both sides. Single-cycle
// operations spend one cycle in EXEC; MUL runs the iterative multiplier.
// The result is held in HOLD until the consumer takes it.
module alu_mc
  import alu_mc_pkg::*;
  #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
  )
  (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             zero,
  output logic             err
  );

  state_e           state_r;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;

  logic             accept_s;
  logic             mul_start_s;
  logic             mul_done_s;
  logic [WIDTH-1:0] mul_p_s;
  logic [WIDTH-1:0] res_s;
  logic             res_err_s;
  logic [SHW-1:0]   shamt_s;

  // Ready depends only on state, out_ready and reset; never on request inputs.
  assign in_ready = rst_n &&
                    ((state_r == ST_IDLE) || ((state_r == ST_HOLD) && out_ready));
  assign accept_s    = in_valid && in_ready;
  // The multiplier captures the raw operands on the accept edge so that its
  // WIDTH iterations start on the very next cycle.
  assign mul_start_s = accept_s && is_mul_op(aluop);
  assign shamt_s     = b_r[SHW-1:0];

  alu_mc_mul #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start_s),
    .a     (a),
    .b     (b),
    .done  (mul_done_s),
    .p     (mul_p_s)
  );

  // Single-cycle result from the registered operands.
  always_comb begin
    res_s     = {WIDTH{1'b0}};
    res_err_s = 1'b0;
    case (aluop_e'(op_r))
      OP_AND:  res_s = a_r & b_r;
      OP_OR:   res_s = a_r | b_r;
      OP_NOT:  res_s = ~a_r;
      OP_ADD:  res_s = a_r + b_r;
      OP_SUB:  res_s = a_r - b_r;
      OP_SHL:  res_s = a_r << shamt_s;
      OP_SHR:  res_s = a_r >> shamt_s;
      OP_SRA:  res_s = $signed(a_r) >>> shamt_s;
      OP_XOR:  res_s = a_r ^ b_r;
      OP_SLT:  res_s = {{(WIDTH-1){1'b0}}, ($signed(a_r) < $signed(b_r))};
      OP_SLTU: res_s = {{(WIDTH-1){1'b0}}, (a_r < b_r)};
      OP_MUL:  res_s = {WIDTH{1'b0}};
      default: begin
        res_s     = {WIDTH{1'b0}};
        res_err_s = 1'b1;
      end
    endcase
  end

  // Controller: captures requests, sequences EXEC/MUL, and holds registered results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      op_r      <= 4'd0;
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      f         <= {WIDTH{1'b0}};
      zero      <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            op_r    <= aluop;
            a_r     <= a;
            b_r     <= b;
            state_r <= is_mul_op(aluop) ? ST_MUL : ST_EXEC;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          f         <= res_s;
          zero      <= (res_s == {WIDTH{1'b0}});
          err       <= res_err_s;
          out_valid <= 1'b1;
          state_r   <= ST_HOLD;
        end
        ST_MUL: begin
          if (mul_done_s) begin
            f         <= mul_p_s;
            zero      <= (mul_p_s == {WIDTH{1'b0}});
            err       <= 1'b0;
            out_valid <= 1'b1;
            state_r   <= ST_HOLD;
          end else begin
            state_r   <= ST_MUL;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (accept_s) begin
              op_r    <= aluop;
              a_r     <= a;
              b_r     <= b;
              state_r <= is_mul_op(aluop) ? ST_MUL : ST_EXEC;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            state_r <= ST_HOLD;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=32): a cycle-level reference model
// checked on every cycle, plus directed vectors with literal expectations.
module tb_alu_mc;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   aluop;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] f;
  logic         zero;
  logic         err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluop     (aluop),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f),
    .zero      (zero),
    .err       (err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference result {err, zero, f} straight from the operation definitions.
  function automatic logic [W+1:0] ref_op(input logic [3:0] op, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    logic [63:0]  prod;
    logic [4:0]   s;
    logic [W-1:0] r;
    logic         e;
    s = y[4:0];
    e = 1'b0;
    r = 32'h0;
    case (op)
      4'd0:  r = x & y;
      4'd1:  r = x | y;
      4'd2:  r = ~x;
      4'd3:  r = x + y;
      4'd4:  r = x - y;
      4'd5:  r = x << s;
      4'd6:  r = x >> s;
      4'd7:  r = (x >> s) | (x[W-1] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
      4'd8:  r = x ^ y;
      4'd9:  r = ((x ^ 32'h8000_0000) < (y ^ 32'h8000_0000)) ? 32'h1 : 32'h0;
      4'd10: r = (x < y) ? 32'h1 : 32'h0;
      4'd11: begin
        prod = {32'h0, x} * {32'h0, y};
        r    = prod[31:0];
      end
      default: begin
        r = 32'h0;
        e = 1'b1;
      end
    endcase
    return {e, (r == 32'h0), r};
  endfunction

  // Model state: countdown to result, pending result, visible result.
  bit           m_started = 1'b0;
  int           m_cnt     = 0;
  logic         m_valid   = 1'b0;
  logic [W-1:0] m_f       = 32'h0;
  logic         m_zero    = 1'b0;
  logic         m_err     = 1'b0;
  logic [W+1:0] m_pend    = 34'h0;

  function automatic logic m_ready();
    return rst_n && (m_cnt == 0) && (!m_valid || out_ready);
  endfunction

  // Model update on each rising edge.
  initial begin
    logic rdy;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_started = 1'b1;
        m_cnt     = 0;
        m_valid   = 1'b0;
        m_f       = 32'h0;
        m_zero    = 1'b0;
        m_err     = 1'b0;
      end else begin
        rdy = m_ready();
        if (m_valid && out_ready) m_valid = 1'b0;
        if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_valid = 1'b1;
            m_err   = m_pend[W+1];
            m_zero  = m_pend[W];
            m_f     = m_pend[W-1:0];
          end
        end
        if (in_valid && rdy) begin
          m_pend = ref_op(aluop, a, b);
          m_cnt  = (aluop == 4'd11) ? (W + 1) : 1;
        end
      end
    end
  end

  // Compare every output against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_started) begin
        chk("cyc_out_valid", {63'h0, out_valid}, {63'h0, m_valid});
        chk("cyc_in_ready",  {63'h0, in_ready},  {63'h0, m_ready()});
        chk("cyc_f",         {32'h0, f},         {32'h0, m_f});
        chk("cyc_zero",      {63'h0, zero},      {63'h0, m_zero});
        chk("cyc_err",       {63'h0, err},       {63'h0, m_err});
      end
    end
  end

  // Present a request for one edge; the model confirms it was accepted.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    aluop    = op;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid after an accept and check latency and result.
  task automatic wait_res(input string name, input int elat, input logic [W-1:0] ef,
                          input logic ez, input logic ee, input bit chk_busy);
    int cyc;
    int rdy_seen;
    cyc      = 0;
    rdy_seen = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (out_valid) break;
      if (in_ready) rdy_seen++;
    end
    chk({name, "_lat"},  cyc, elat);
    chk({name, "_f"},    {32'h0, f}, {32'h0, ef});
    chk({name, "_zero"}, {63'h0, zero}, {63'h0, ez});
    chk({name, "_err"},  {63'h0, err},  {63'h0, ee});
    if (chk_busy) chk({name, "_busy_ready"}, rdy_seen, 0);
  endtask

  logic [3:0]   v_op [12];
  logic [W-1:0] v_a  [12];
  logic [W-1:0] v_b  [12];
  logic [W-1:0] v_f  [12];
  logic         v_z  [12];
  logic         v_e  [12];

  initial begin
    int nv;
    // op, a, b, expected f, zero, err
    v_op[0]  = 4'd3;  v_a[0]  = 32'hFFFF_FFFF; v_b[0]  = 32'h1;         v_f[0]  = 32'h0;         v_z[0]  = 1'b1; v_e[0]  = 1'b0;
    v_op[1]  = 4'd7;  v_a[1]  = 32'h8000_0000; v_b[1]  = 32'd36;        v_f[1]  = 32'hF800_0000; v_z[1]  = 1'b0; v_e[1]  = 1'b0;
    v_op[2]  = 4'd6;  v_a[2]  = 32'h8000_0000; v_b[2]  = 32'd36;        v_f[2]  = 32'h0800_0000; v_z[2]  = 1'b0; v_e[2]  = 1'b0;
    v_op[3]  = 4'd9;  v_a[3]  = 32'hFFFF_FFFF; v_b[3]  = 32'h1;         v_f[3]  = 32'h1;         v_z[3]  = 1'b0; v_e[3]  = 1'b0;
    v_op[4]  = 4'd10; v_a[4]  = 32'hFFFF_FFFF; v_b[4]  = 32'h1;         v_f[4]  = 32'h0;         v_z[4]  = 1'b1; v_e[4]  = 1'b0;
    v_op[5]  = 4'd0;  v_a[5]  = 32'h0000_F0F0; v_b[5]  = 32'h0000_FF00; v_f[5]  = 32'h0000_F000; v_z[5]  = 1'b0; v_e[5]  = 1'b0;
    v_op[6]  = 4'd1;  v_a[6]  = 32'h0000_F0F0; v_b[6]  = 32'h0000_FF00; v_f[6]  = 32'h0000_FFF0; v_z[6]  = 1'b0; v_e[6]  = 1'b0;
    v_op[7]  = 4'd2;  v_a[7]  = 32'h0F0F_0F0F; v_b[7]  = 32'h1234_5678; v_f[7]  = 32'hF0F0_F0F0; v_z[7]  = 1'b0; v_e[7]  = 1'b0;
    v_op[8]  = 4'd4;  v_a[8]  = 32'd5;         v_b[8]  = 32'd7;         v_f[8]  = 32'hFFFF_FFFE; v_z[8]  = 1'b0; v_e[8]  = 1'b0;
    v_op[9]  = 4'd5;  v_a[9]  = 32'h1;         v_b[9]  = 32'd33;        v_f[9]  = 32'h2;         v_z[9]  = 1'b0; v_e[9]  = 1'b0;
    v_op[10] = 4'd8;  v_a[10] = 32'hFFFF_0000; v_b[10] = 32'h0F0F_0F0F; v_f[10] = 32'hF0F0_0F0F; v_z[10] = 1'b0; v_e[10] = 1'b0;
    v_op[11] = 4'd13; v_a[11] = 32'h1;         v_b[11] = 32'h2;         v_f[11] = 32'h0;         v_z[11] = 1'b1; v_e[11] = 1'b1;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    aluop     = 4'd0;
    a         = 32'h0;
    b         = 32'h0;
    out_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_in_ready",  {63'h0, in_ready},  64'h0);
    chk("rst_f",         {32'h0, f},         64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single-cycle operations, one at a time.
    for (int i = 0; i < 12; i++) begin
      issue(v_op[i], v_a[i], v_b[i]);
      wait_res($sformatf("vec%0d", i), 2, v_f[i], v_z[i], v_e[i], 1'b0);
      @(posedge clk);
      #1;
    end

    // Multiply: WIDTH+2 latency with in_ready low throughout.
    issue(4'd11, 32'h0001_0003, 32'h5);
    wait_res("mul", 34, 32'h0005_000F, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;

    // Back-to-back stream with out_ready high: one result every two cycles.
    nv = 0;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          aluop    = 4'd3;
          a        = k;
          b        = 32'd100;
          in_valid = 1'b1;
          @(posedge clk);
          @(posedge clk);
          #1;
        end
        in_valid = 1'b0;
      end
      begin
        repeat (12) begin
          @(negedge clk);
          if (out_valid) nv++;
        end
      end
    join
    chk("stream_results", nv, 4);
    @(posedge clk);
    #1;

    // Back-pressure in HOLD, then release with a new (illegal) request that edge.
    out_ready = 1'b0;
    issue(4'd3, 32'd2, 32'd3);
    wait_res("hold_add", 2, 32'd5, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("hold_f_%0d", k),        {32'h0, f},         64'd5);
      chk($sformatf("hold_in_ready_%0d", k), {63'h0, in_ready},  64'h0);
      chk($sformatf("hold_valid_%0d", k),    {63'h0, out_valid}, 64'h1);
    end
    #1;
    out_ready = 1'b1;
    issue(4'd12, 32'hDEAD_BEEF, 32'h1);
    wait_res("illegal", 2, 32'h0, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #1;

    // One-cycle reset in the middle of a multiply discards it.
    issue(4'd11, 32'd7, 32'd9);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("mrst_f",         {32'h0, f},         64'h0);
    chk("mrst_in_ready",  {63'h0, in_ready},  64'h1);
    nv = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    chk("mrst_no_late_result", nv, 0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "time limit");
  end

endmodule
